// File: rtl/regfile_wb.sv
// Dual-channel register-file writeback: one FIFO per channel drains into a
// registered write port, with a busy scoreboard for issue-stage hazard checks.

module regfile_wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [4:0]  push_addr,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        head_vld,
  output logic [4:0]  head_addr,
  output logic [31:0] head_data
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]              count_q, count_d;
  logic [DEPTH-1:0][36:0]   mem_q, mem_d;
  logic                     push;

  always_comb begin
    push_ready = count_q != (AW+1)'(DEPTH);
    head_vld   = count_q != '0;
    {head_addr, head_data} = mem_q[rd_ptr_q];
    push       = push_valid && push_ready;
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = {push_addr, push_data};
    // pointers wrap naturally because DEPTH is a power of two
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end
endmodule

module regfile_wb #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  input  logic        hold,
  input  logic        rsv_en,
  input  logic [4:0]  rsv_addr,
  input  logic [4:0]  chk_addr0,
  input  logic [4:0]  chk_addr1,
  output logic        hazard,
  output logic        wen0,
  output logic [4:0]  waddr0,
  output logic [31:0] wdata0,
  output logic        wen1,
  output logic [4:0]  waddr1,
  output logic [31:0] wdata1,
  output logic [31:0] busy,
  output logic [15:0] collisions
);
  logic [1:0]        ch_valid, ch_ready, hd_vld, pop;
  logic [1:0][4:0]   ch_addr, hd_addr;
  logic [1:0][31:0]  ch_data, hd_data;

  assign ch_valid = {req1_valid, req0_valid};
  assign ch_addr  = {req1_addr, req0_addr};
  assign ch_data  = {req1_data, req0_data};
  assign req0_ready = ch_ready[0];
  assign req1_ready = ch_ready[1];

  for (genvar g = 0; g < 2; g++) begin : g_ch
    regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (ch_valid[g]),
      .push_ready (ch_ready[g]),
      .push_addr  (ch_addr[g]),
      .push_data  (ch_data[g]),
      .pop        (pop[g]),
      .head_vld   (hd_vld[g]),
      .head_addr  (hd_addr[g]),
      .head_data  (hd_data[g])
    );
  end

  logic        wen0_q, wen0_d, wen1_q, wen1_d, coll;
  logic [4:0]  waddr0_q, waddr0_d, waddr1_q, waddr1_d;
  logic [31:0] wdata0_q, wdata0_d, wdata1_q, wdata1_d, busy_q, busy_d;
  logic [15:0] collisions_q, collisions_d;

  always_comb begin
    pop      = {2{~hold}} & hd_vld;
    coll     = &pop && hd_addr[0] == hd_addr[1] && hd_addr[1] != '0;
    wen0_d   = pop[0] && hd_addr[0] != '0;
    wen1_d   = pop[1] && hd_addr[1] != '0 && !coll;
    waddr0_d = wen0_d ? hd_addr[0] : waddr0_q;
    wdata0_d = wen0_d ? hd_data[0] : wdata0_q;
    waddr1_d = wen1_d ? hd_addr[1] : waddr1_q;
    wdata1_d = wen1_d ? hd_data[1] : wdata1_q;
    collisions_d = (coll && collisions_q != 16'hFFFF) ? collisions_q + 16'd1 : collisions_q;
    busy_d = busy_q;
    if (wen0_d) busy_d[hd_addr[0]] = 1'b0;
    if (wen1_d) busy_d[hd_addr[1]] = 1'b0;
    // reservation applied last so a same-edge set beats the clear
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen0_q       <= 1'b0;
      wen1_q       <= 1'b0;
      waddr0_q     <= '0;
      wdata0_q     <= '0;
      waddr1_q     <= '0;
      wdata1_q     <= '0;
      busy_q       <= '0;
      collisions_q <= '0;
    end else begin
      wen0_q       <= wen0_d;
      wen1_q       <= wen1_d;
      waddr0_q     <= waddr0_d;
      wdata0_q     <= wdata0_d;
      waddr1_q     <= waddr1_d;
      wdata1_q     <= wdata1_d;
      busy_q       <= busy_d;
      collisions_q <= collisions_d;
    end
  end

  assign wen0       = wen0_q;
  assign waddr0     = waddr0_q;
  assign wdata0     = wdata0_q;
  assign wen1       = wen1_q;
  assign waddr1     = waddr1_q;
  assign wdata1     = wdata1_q;
  assign busy       = busy_q;
  assign collisions = collisions_q;
  assign hazard     = (chk_addr0 != '0 && busy_q[chk_addr0]) ||
                      (chk_addr1 != '0 && busy_q[chk_addr1]);
endmodule

// File: tb/tb_regfile_wb.sv
// Randomized bench for regfile_wb: queue-based reference model feeds expected
// writes into scoreboard queues; a negedge monitor pops and compares.

module tb_regfile_wb;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0, hold = 0, rsv_en = 0;
  logic [4:0]  req0_addr = 0, req1_addr = 0, rsv_addr = 0, chk_addr0 = 0, chk_addr1 = 0;
  logic [31:0] req0_data = 0, req1_data = 0;
  logic        req0_ready, req1_ready, hazard, wen0, wen1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1, busy;
  logic [15:0] collisions;

  regfile_wb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .hold(hold), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .chk_addr0(chk_addr0), .chk_addr1(chk_addr1),
    .hazard(hazard), .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1), .busy(busy), .collisions(collisions)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [31:0] d; int c; } ent_t;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  ent_t        q0[$], q1[$], e0[$], e1[$];
  logic [31:0] m_busy;
  logic [4:0]  m_waddr0, m_waddr1;
  logic [31:0] m_wdata0, m_wdata1;
  int          m_coll, cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete(); q1.delete(); e0.delete(); e1.delete();
      m_busy = 0; m_waddr0 = 0; m_waddr1 = 0; m_wdata0 = 0; m_wdata1 = 0; m_coll = 0;
    end else begin
      automatic bit r0 = q0.size() < DEPTH, r1 = q1.size() < DEPTH;
      automatic bit p0 = 0, p1 = 0;
      automatic ent_t h0, h1;
      cyc++;
      if (!hold && q0.size() > 0) begin h0 = q0.pop_front(); p0 = 1; end
      if (!hold && q1.size() > 0) begin h1 = q1.pop_front(); p1 = 1; end
      if (p0 && h0.a != 0) begin
        m_busy[h0.a] = 0; m_waddr0 = h0.a; m_wdata0 = h0.d;
        e0.push_back('{h0.a, h0.d, cyc});
      end
      if (p1 && h1.a != 0) begin
        if (p0 && h0.a == h1.a) begin
          if (m_coll < 65535) m_coll++;
        end else begin
          m_busy[h1.a] = 0; m_waddr1 = h1.a; m_wdata1 = h1.d;
          e1.push_back('{h1.a, h1.d, cyc});
        end
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
      if (req0_valid && r0) q0.push_back('{req0_addr, req0_data, 0});
      if (req1_valid && r1) q1.push_back('{req1_addr, req1_data, 0});
    end
  end

  // monitor: compare every presented write against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (wen0) begin
        if (e0.size() == 0) chk("wen0_unexpected", 1, 0);
        else begin
          automatic ent_t x = e0.pop_front();
          chk("w0_addr", waddr0, x.a); chk("w0_data", wdata0, x.d); chk("w0_cycle", cyc, x.c);
        end
      end else if (e0.size() > 0 && e0[0].c <= cyc) begin
        chk("w0_missing", 0, 1); void'(e0.pop_front());
      end
      if (wen1) begin
        if (e1.size() == 0) chk("wen1_unexpected", 1, 0);
        else begin
          automatic ent_t x = e1.pop_front();
          chk("w1_addr", waddr1, x.a); chk("w1_data", wdata1, x.d); chk("w1_cycle", cyc, x.c);
        end
      end else if (e1.size() > 0 && e1[0].c <= cyc) begin
        chk("w1_missing", 0, 1); void'(e1.pop_front());
      end
      chk("waddr0_hold", waddr0, m_waddr0); chk("wdata0_hold", wdata0, m_wdata0);
      chk("waddr1_hold", waddr1, m_waddr1); chk("wdata1_hold", wdata1, m_wdata1);
      chk("req0_ready", req0_ready, q0.size() < DEPTH);
      chk("req1_ready", req1_ready, q1.size() < DEPTH);
      chk("busy", busy, m_busy);
      chk("collisions", collisions, m_coll);
      chk("hazard", hazard, (chk_addr0 != 0 && m_busy[chk_addr0]) || (chk_addr1 != 0 && m_busy[chk_addr1]));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; rsv_en = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wen0"}, wen0, 0);   chk({tag, "_wen1"}, wen1, 0);
    chk({tag, "_waddr0"}, waddr0, 0); chk({tag, "_wdata0"}, wdata0, 0);
    chk({tag, "_waddr1"}, waddr1, 0); chk({tag, "_wdata1"}, wdata1, 0);
    chk({tag, "_busy"}, busy, 0);   chk({tag, "_coll"}, collisions, 0);
    chk({tag, "_rdy0"}, req0_ready, 1); chk({tag, "_rdy1"}, req1_ready, 1);
  endtask

  initial begin
    #3 chk_reset_vals("reset");
    #19 rst_n = 1;
    step();

    // single write to r5
    req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF; step();
    idle(); step(3);

    // reserve r7, hazard, then clear by writeback
    rsv_en = 1; rsv_addr = 7; step();
    idle(); chk_addr0 = 7; #1 chk("hazard_r7", hazard, 1); step();
    req0_valid = 1; req0_addr = 7; req0_data = 32'h77; step();
    idle(); step(3);
    chk("hazard_r7_clear", hazard, 0);

    // same-edge collision on r9
    rsv_en = 1; rsv_addr = 9; step();
    idle();
    req0_valid = 1; req0_addr = 9; req0_data = 1;
    req1_valid = 1; req1_addr = 9; req1_data = 2; step();
    idle(); step(3);
    chk("collision_one", collisions, 1);

    // hold fill: DEPTH+1 back-to-back pushes on req1
    hold = 1;
    for (int i = 0; i <= DEPTH; i++) begin
      req1_valid = 1; req1_addr = 5'(10 + i); req1_data = 32'h100 + i; step();
    end
    idle(); chk("fill_ready_low", req1_ready, 0);
    step(2); hold = 0; step(DEPTH + 3);

    // r0 write and r0 reservation are ignored
    req0_valid = 1; req0_addr = 0; req0_data = 32'h1; rsv_en = 1; rsv_addr = 0; step();
    idle(); step(3);
    chk("r0_busy", busy, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      req0_valid = 1'($urandom); req0_addr = 5'($urandom_range(0, 7)); req0_data = $urandom;
      req1_valid = 1'($urandom); req1_addr = 5'($urandom_range(0, 7)); req1_data = $urandom;
      hold = ($urandom_range(0, 4) == 0);
      rsv_en = 1'($urandom); rsv_addr = 5'($urandom_range(0, 7));
      chk_addr0 = 5'($urandom_range(0, 7)); chk_addr1 = 5'($urandom_range(0, 7));
      step();
    end
    idle(); hold = 0; step(DEPTH + 3);

    // mid-operation reset with 3 queued entries
    rsv_en = 1; rsv_addr = 3; step();
    idle(); hold = 1;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_addr = 5'(20 + i); req0_data = 32'hA0 + i; step();
    end
    idle();
    #2 rst_n = 0;
    #1 chk_reset_vals("midreset");
    step(2);
    rst_n = 1; hold = 0; step(DEPTH + 4);
    chk("post_reset_no_wen0", wen0, 0);

    chk("drain_e0", e0.size(), 0);
    chk("drain_e1", e1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
